lion_gate_emulator: RTL and testbench
=====================================

Name: lion_gate_emulator

Overview:
Stimulus-side counterpart of the lion-cage counter. It turns "lion enters" / "lion exits" commands into timed two-gate light-barrier sequences on g_one/g_two. It keeps its own 4-bit expected lion count and checks that count against the counter's value after each sequence. It is instantiated in the demo/test wrapper ahead of the counter, so the counter and its 7-segment display can be exercised without physical barriers.

Parameters:
PHASE_CYCLES, 4, clock cycles each gate phase is held; legal range 1..255.

Ports:
clk        input   1  clock
reset      input   1  reset, synchronous, active-high
cmd_valid  input   1  command request
cmd_dir    input   1  0 = enter (+1), 1 = exit (-1); sampled on handshake
cmd_ready  output  1  high only in IDLE
g_one      output  1  gate one barrier signal, registered
g_two      output  1  gate two barrier signal, registered
busy       output  1  high while a sequence is in progress (state != IDLE)
done       output  1  one-cycle pulse when a sequence completes
exp_count  output  4  expected lion count, mod 16
obs_count  input   4  count reported by the counter under test
mismatch   output  1  sticky error flag

Behaviour:
- Gate protocol the counter implements:
  - +1 on a g_one rising edge while g_two = 0.
  - -1 on a g_one falling edge while g_two = 0.
  - g_one edges while g_two = 1 do not change the count.
- Reset (synchronous, any state, including mid-sequence):
  - state = IDLE; g_one = g_two = 0; done = 0; exp_count = 0; mismatch = 0; phase timer = 0.
- States: IDLE, P1, P2, P3, P4, CHECK.
- Handshake:
  - cmd_ready = (state == IDLE).
  - Accept when cmd_valid && cmd_ready; cmd_dir is latched into a dir register.
  - The next cycle enters P1 with new gate values.
  - cmd_valid while not ready is ignored; the requester holds it.
- Gate values {g_one, g_two} per phase:
  - Enter: P1 = 10, P2 = 11, P3 = 01, P4 = 00.
  - Exit: P1 = 01, P2 = 11, P3 = 10, P4 = 00.
  - IDLE and CHECK: 00.
- Net effect: enter produces exactly one +1 edge (start of P1); exit produces exactly one -1 edge (start of P4).
- Phase timing:
  - Each of P1..P4 lasts exactly PHASE_CYCLES cycles, counted by the timer.
  - The timer reloads on every phase entry.
  - After the last P4 cycle, the FSM goes to CHECK for one cycle, then to IDLE.
- Completion (in the CHECK cycle):
  - done = 1.
  - exp_count is already updated: +1 for enter with 15 -> 0 wrap; -1 for exit with 0 -> 15 wrap.
  - obs_count is compared with the updated exp_count; inequality sets mismatch, which is sticky until reset.
  - The counter settles within one cycle of the P4 gate edge, so obs_count is valid by CHECK.
- Total latency, accept to done: 4*PHASE_CYCLES + 1 cycles.
- Back-to-back commands: at least one IDLE cycle (gates 00) between sequences.
- busy = 1 in P1..P4 and CHECK.
- No abort path other than reset.

Decomposition:
- Package lion_pkg:
  - DIR_ENTER = 1'b0, DIR_EXIT = 1'b1.
  - State enum encoding.
  - Per-direction phase gate-value constants.
  - LION_CNT_W = 4.
- One natural sub-module: lion_phase_timer (8-bit load/decrement down-counter with a "last" flag). The FSM and exp_count stay in the top module.

Test Plan:
- Reset, then one enter with PHASE_CYCLES = 2, obs_count driven as 1 at CHECK:
  - gates go 10, 11, 01, 00, each for 2 cycles.
  - done pulses 9 cycles after accept.
  - exp_count = 1, mismatch = 0.
- 16 back-to-back enters from 0:
  - exp_count goes 1..15 then wraps to 0.
  - cmd_ready is low for exactly 9 cycles per command at PHASE_CYCLES = 2.
- Exit from exp_count = 0:
  - gates go 01, 11, 10, 00.
  - exp_count = 15.
  - the only g_one falling edge occurs with g_two = 0.
- obs_count held at 0 during an enter:
  - mismatch = 1 after CHECK and stays 1 across later correct sequences until reset.
- reset asserted during P2:
  - next cycle g_one = g_two = 0, state IDLE, exp_count = 0, no done pulse.
- cmd_valid held high while busy, with cmd_dir toggling:
  - only the dir value sampled at the accept cycle is used.
  - a second command is accepted only in the IDLE cycle after CHECK.

Source files
------------

// File: rtl/lion_pkg.sv
// Shared types and constants for the lion gate emulator.
// Gate values are packed as {g_one, g_two}.
package lion_pkg;

    localparam int LION_CNT_W = 4;
    localparam int TIMER_W    = 8;

    localparam logic DIR_ENTER = 1'b0;
    localparam logic DIR_EXIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        P1    = 3'd1,
        P2    = 3'd2,
        P3    = 3'd3,
        P4    = 3'd4,
        CHECK = 3'd5
    } state_t;

    typedef logic [1:0] gate_t;

    localparam gate_t GATES_OFF = 2'b00;

    // Enter: g_one rises first while g_two is low -> one +1 edge at P1.
    localparam gate_t ENTER_P1 = 2'b10;
    localparam gate_t ENTER_P2 = 2'b11;
    localparam gate_t ENTER_P3 = 2'b01;
    localparam gate_t ENTER_P4 = 2'b00;

    // Exit: g_one rises while g_two is high (ignored), falls with g_two low
    // at P4 -> one -1 edge.
    localparam gate_t EXIT_P1 = 2'b01;
    localparam gate_t EXIT_P2 = 2'b11;
    localparam gate_t EXIT_P3 = 2'b10;
    localparam gate_t EXIT_P4 = 2'b00;

    // Gate pattern driven while in a given state for a given direction.
    function automatic gate_t phase_gates(input logic dir, input state_t st);
        gate_t g;
        g = GATES_OFF;
        case (st)
            P1:      g = (dir == DIR_EXIT) ? EXIT_P1 : ENTER_P1;
            P2:      g = (dir == DIR_EXIT) ? EXIT_P2 : ENTER_P2;
            P3:      g = (dir == DIR_EXIT) ? EXIT_P3 : ENTER_P3;
            P4:      g = (dir == DIR_EXIT) ? EXIT_P4 : ENTER_P4;
            default: g = GATES_OFF;
        endcase
        return g;
    endfunction

    // Successor of a timed phase; P4 hands over to the CHECK cycle.
    function automatic state_t next_phase(input state_t st);
        state_t n;
        n = IDLE;
        case (st)
            P1:      n = P2;
            P2:      n = P3;
            P3:      n = P4;
            P4:      n = CHECK;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lion_gate_emulator_timer.sv
// Phase timer: loadable 8-bit down-counter. 'last' marks the final cycle of
// the current phase (count has reached zero).
module lion_phase_timer
    import lion_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    input  logic               dec,
    output logic               last
);

    logic [TIMER_W-1:0] count;

    // Reload on phase entry, otherwise count down to zero and hold there.
    // NOTE: clocked state is written with <= so every register samples the
    // pre-edge values; blocking '=' here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/lion_gate_emulator.sv
// Lion gate emulator: turns enter/exit commands into timed two-gate barrier
// sequences, tracks the expected lion count and flags any disagreement with
// the counter under test.
module lion_gate_emulator
    import lion_pkg::*;
#(
    parameter int PHASE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    input  logic                  cmd_dir,
    output logic                  cmd_ready,
    output logic                  g_one,
    output logic                  g_two,
    output logic                  busy,
    output logic                  done,
    output logic [LION_CNT_W-1:0] exp_count,
    input  logic [LION_CNT_W-1:0] obs_count,
    output logic                  mismatch
);

    // Timer counts PHASE_CYCLES-1 .. 0, so each phase spans PHASE_CYCLES cycles.
    localparam logic [TIMER_W-1:0]    PHASE_LOAD = TIMER_W'(PHASE_CYCLES - 1);
    localparam logic [LION_CNT_W-1:0] CNT_ONE    = LION_CNT_W'(1);

    state_t state;
    logic   dir;
    logic   accept;
    logic   in_phase;
    logic   timer_load;
    logic   timer_dec;
    logic   timer_last;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign in_phase  = (state == P1) || (state == P2) || (state == P3) || (state == P4);

    // Timer control: reload on accept and on every P1..P3 -> next phase step.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        if (accept) begin
            timer_load = 1'b1;
        end else if (in_phase) begin
            timer_dec = 1'b1;
            if (timer_last && (state != P4)) begin
                timer_load = 1'b1;
            end
        end
    end

    lion_phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (PHASE_LOAD),
        .dec        (timer_dec),
        .last       (timer_last)
    );

    // Sequencer FSM with registered gate, done, count and error outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dir       <= DIR_ENTER;
            g_one     <= 1'b0;
            g_two     <= 1'b0;
            done      <= 1'b0;
            exp_count <= '0;
            mismatch  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dir            <= cmd_dir;
                        state          <= P1;
                        {g_one, g_two} <= phase_gates(cmd_dir, P1);
                    end
                end
                P1, P2, P3: begin
                    if (timer_last) begin
                        state          <= next_phase(state);
                        {g_one, g_two} <= phase_gates(dir, next_phase(state));
                    end
                end
                P4: begin
                    if (timer_last) begin
                        state          <= CHECK;
                        {g_one, g_two} <= GATES_OFF;
                        done           <= 1'b1;
                        // Count is updated on entry to CHECK; mod-16 wrap is natural.
                        exp_count      <= (dir == DIR_EXIT) ? (exp_count - CNT_ONE)
                                                            : (exp_count + CNT_ONE);
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (obs_count != exp_count) begin
                        mismatch <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    {g_one, g_two} <= GATES_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lion_gate_emulator.sv
// Directed bench for lion_gate_emulator at PHASE_CYCLES = 2.
module tb_lion_gate_emulator;

    localparam int PC      = 2;
    localparam int SEQ_LEN = 4 * PC + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_dir;
    logic       cmd_ready;
    logic       g_one;
    logic       g_two;
    logic       busy;
    logic       done;
    logic [3:0] exp_count;
    logic [3:0] obs_count;
    logic       mismatch;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-sequence capture filled by run_seq.
    logic [1:0] gate_log [1:SEQ_LEN];
    int         ready_low;
    int         done_cnt;
    int         done_at;
    int         fall_g2_lo;
    int         fall_g2_hi;

    lion_gate_emulator #(.PHASE_CYCLES(PC)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_ready (cmd_ready),
        .g_one     (g_one),
        .g_two     (g_two),
        .busy      (busy),
        .done      (done),
        .exp_count (exp_count),
        .obs_count (obs_count),
        .mismatch  (mismatch)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        obs_count = 4'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Hand-written gate tables: sample k (1-based after accept) -> {g_one,g_two}.
    function automatic logic [1:0] exp_gate(input logic d, input int k);
        if (k > 4 * PC) return 2'b00;
        case ((k - 1) / PC)
            0:       return d ? 2'b01 : 2'b10;
            1:       return 2'b11;
            2:       return d ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Issue one command, capture SEQ_LEN post-accept samples, end in the IDLE cycle.
    task automatic run_seq(input logic d, input logic [3:0] obs);
        logic prev_g1;
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        obs_count  = obs;
        prev_g1    = g_one;
        ready_low  = 0;
        done_cnt   = 0;
        done_at    = 0;
        fall_g2_lo = 0;
        fall_g2_hi = 0;
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k <= SEQ_LEN; k++) begin
            gate_log[k] = {g_one, g_two};
            if (!cmd_ready) ready_low++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (prev_g1 && !g_one) begin
                if (g_two) fall_g2_hi++;
                else       fall_g2_lo++;
            end
            prev_g1 = g_one;
            step();
        end
    endtask

    initial begin
        logic [3:0] want;
        int         dcnt;

        // Reset state
        reset_dut();
        check("rst_g_one", 8'(g_one), 8'd0);
        check("rst_g_two", 8'(g_two), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_exp_count", 8'(exp_count), 8'd0);
        check("rst_mismatch", 8'(mismatch), 8'd0);
        check("rst_cmd_ready", 8'(cmd_ready), 8'd1);
        check("rst_busy", 8'(busy), 8'd0);

        // Single enter, obs=1 at CHECK
        run_seq(1'b0, 4'd1);
        for (int k = 1; k <= SEQ_LEN; k++) begin
            check($sformatf("enter_gate_k%0d", k), 8'(gate_log[k]), 8'(exp_gate(1'b0, k)));
        end
        check("enter_done_at", 8'(done_at), 8'd9);
        check("enter_done_cnt", 8'(done_cnt), 8'd1);
        check("enter_exp_count", 8'(exp_count), 8'd1);
        check("enter_mismatch", 8'(mismatch), 8'd0);
        check("enter_ready_after", 8'(cmd_ready), 8'd1);
        check("enter_fall_g2_lo", 8'(fall_g2_lo), 8'd0);

        // 16 back-to-back enters from 0, wrapping to 0
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            want = 4'(i + 1);
            run_seq(1'b0, want);
            check($sformatf("b2b_exp_count_%0d", i), 8'(exp_count), 8'(want));
            check($sformatf("b2b_ready_low_%0d", i), 8'(ready_low), 8'd9);
        end
        check("b2b_mismatch", 8'(mismatch), 8'd0);

        // Exit from 0 wraps to 15
        run_seq(1'b1, 4'd15);
        for (int k = 1; k <= SEQ_LEN; k += PC) begin
            check($sformatf("exit_gate_k%0d", k), 8'(gate_log[k]), 8'(exp_gate(1'b1, k)));
        end
        check("exit_exp_count", 8'(exp_count), 8'd15);
        check("exit_fall_g2_lo", 8'(fall_g2_lo), 8'd1);
        check("exit_fall_g2_hi", 8'(fall_g2_hi), 8'd0);
        check("exit_done_at", 8'(done_at), 8'd9);
        check("exit_mismatch", 8'(mismatch), 8'd0);

        // Wrong obs_count sets a sticky mismatch
        reset_dut();
        run_seq(1'b0, 4'd0);
        check("mm_exp_count", 8'(exp_count), 8'd1);
        check("mm_set", 8'(mismatch), 8'd1);
        run_seq(1'b0, 4'd2);
        check("mm_sticky_count", 8'(exp_count), 8'd2);
        check("mm_sticky", 8'(mismatch), 8'd1);
        run_seq(1'b1, 4'd1);
        check("mm_sticky2", 8'(mismatch), 8'd1);
        reset_dut();
        check("mm_cleared", 8'(mismatch), 8'd0);

        // Reset asserted during P2
        run_seq(1'b0, 4'd1);
        check("rp2_pre_count", 8'(exp_count), 8'd1);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        obs_count = 4'd2;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("rp2_in_p2", 8'({g_one, g_two}), 8'b11);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rp2_g_one", 8'(g_one), 8'd0);
        check("rp2_g_two", 8'(g_two), 8'd0);
        check("rp2_idle", 8'(cmd_ready), 8'd1);
        check("rp2_busy", 8'(busy), 8'd0);
        check("rp2_exp_count", 8'(exp_count), 8'd0);
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) dcnt++;
            step();
        end
        check("rp2_no_done", 8'(dcnt), 8'd0);

        // cmd_valid held high with cmd_dir toggling while busy
        reset_dut();
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        obs_count = 4'd1;
        step();
        for (int k = 1; k <= SEQ_LEN; k++) begin
            check($sformatf("hold_gate_k%0d", k), 8'({g_one, g_two}), 8'(exp_gate(1'b0, k)));
            check($sformatf("hold_busy_k%0d", k), 8'(busy), 8'd1);
            cmd_dir = ~cmd_dir;
            if (k == SEQ_LEN) begin
                check("hold_done", 8'(done), 8'd1);
                cmd_dir = 1'b1;
            end
            step();
        end
        check("hold_idle_ready", 8'(cmd_ready), 8'd1);
        check("hold_exp_count", 8'(exp_count), 8'd1);
        obs_count = 4'd0;
        step();
        cmd_valid = 1'b0;
        check("hold_second_accept", 8'(busy), 8'd1);
        check("hold_second_gate", 8'({g_one, g_two}), 8'(exp_gate(1'b1, 1)));
        for (int k = 2; k <= SEQ_LEN; k++) begin
            step();
            check($sformatf("hold_exit_gate_k%0d", k), 8'({g_one, g_two}), 8'(exp_gate(1'b1, k)));
        end
        step();
        check("hold_final_count", 8'(exp_count), 8'd0);
        check("hold_final_mismatch", 8'(mismatch), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
